norm_stream_scaler: RTL and testbench

- Per-frame pixel normaliser. Sits between the crop stage and the downstream inference stream.
- On each `ap_start` it latches a denominator and computes the fixed-point coefficient with an on-block iterative divider.
- It then scales every pixel of one frame to full scale, LANES pixels per beat, with rounding and saturation.
- Output goes through a credit-protected FIFO that carries `tlast`, and an `ap_done` pulse marks the end of the frame.

---
 rtl/norm_stream_scaler_if.sv | 20 ++
 rtl/norm_stream_scaler.sv | 159 +++++++++++++++
 tb/tb_norm_stream_scaler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/norm_stream_scaler_if.sv
// norm_stream_scaler_if: frame control and AXI-stream signals of the pixel normaliser
interface norm_stream_scaler_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 1
);
  logic ap_start, ap_ready, ap_idle, ap_done;
  logic [PIX_W-1:0] norm_denominator;
  logic s_axis_tvalid, s_axis_tready;
  logic [LANES*PIX_W-1:0] s_axis_tdata;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [LANES*PIX_W-1:0] m_axis_tdata;
  modport master (
    output ap_start, norm_denominator, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input ap_ready, ap_idle, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
  modport slave (
    input ap_start, norm_denominator, s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output ap_ready, ap_idle, ap_done, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/norm_stream_scaler.sv
// norm_stream_scaler: per-frame pixel normaliser with iterative reciprocal and credit-protected output FIFO
module norm_stream_scaler #(
  parameter int PIX_W = 8,
  parameter int LANES = 1,
  parameter int FRAC_W = 16,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic reset,
  norm_stream_scaler_if.slave io
);
  localparam int FRAME_BEATS = OUT_ROWS * OUT_COLS / LANES;
  localparam int CW = PIX_W + FRAC_W;
  localparam int PW = PIX_W + CW + 1;
  localparam int HW = PW - FRAC_W;
  localparam int DW = LANES * PIX_W;
  localparam int IW = $clog2(FRAME_BEATS + 1);
  localparam int RW = $clog2(CW);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [PIX_W-1:0] SCALE = '1;
  localparam logic [CW-1:0] DIVIDEND = {SCALE, {FRAC_W{1'b0}}};
  localparam logic [CW-1:0] UNITY = CW'(1) << FRAC_W;
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_W - 1);

  typedef enum logic [1:0] {IDLE, RECIP, RUN, DONE} state_t;
  state_t state, nxt;

  logic alive, bypass, fits, start, in_hs, out_hs, room;
  logic [PIX_W-1:0] den, rem;
  logic [PIX_W:0] trial;
  logic [CW-1:0] coef, eff_coef;
  logic [RW-1:0] rcnt;
  logic [IW-1:0] in_cnt;
  logic s1_v, s1_last, s2_v, s2_last;
  logic [PW-1:0] p1 [LANES];
  logic [DW-1:0] sat, s2_data;
  logic [DW:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;

  assign start = state == IDLE && io.ap_start;
  assign in_hs = io.s_axis_tvalid && io.s_axis_tready;
  assign out_hs = io.m_axis_tvalid && io.m_axis_tready;
  assign room = ({1'b0, cnt} + (AW+2)'(s1_v) + (AW+2)'(s2_v)) < (AW+2)'(FIFO_DEPTH);
  assign trial = {rem, coef[CW-1]};
  assign fits = trial >= {1'b0, den};
  assign eff_coef = bypass ? UNITY : coef;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nxt;
  end

  // next state: a zero denominator skips the divider and passes pixels through
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: nxt = io.ap_start ? (io.norm_denominator == '0 ? RUN : RECIP) : IDLE;
      RECIP: nxt = rcnt == RW'(CW - 1) ? RUN : RECIP;
      RUN: nxt = out_hs && io.m_axis_tlast ? DONE : RUN;
      default: nxt = IDLE;
    endcase
  end

  // control outputs; input is admitted only while FIFO plus pipeline has a free slot
  always_comb begin
    io.ap_idle = alive && state == IDLE;
    io.ap_ready = alive && state == IDLE;
    io.ap_done = state == DONE;
    io.s_axis_tready = state == RUN && in_cnt < IW'(FRAME_BEATS) && room;
  end

  // holds ready/idle low until the first edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) alive <= 1'b0;
    else alive <= 1'b1;
  end

  // restoring divider: coef doubles as the dividend shift register and ends as the quotient
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      den <= '0;
      rem <= '0;
      coef <= '0;
      rcnt <= '0;
      bypass <= 1'b0;
    end else if (start) begin
      den <= io.norm_denominator;
      rem <= '0;
      coef <= DIVIDEND;
      rcnt <= '0;
      bypass <= io.norm_denominator == '0;
    end else if (state == RECIP) begin
      rem <= fits ? PIX_W'(trial - {1'b0, den}) : trial[PIX_W-1:0];
      coef <= {coef[CW-2:0], fits};
      rcnt <= rcnt + 1'b1;
    end else if (state == DONE) begin
      bypass <= 1'b0;
    end
  end

  // accepted input beats of the current frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_cnt <= '0;
    else if (state == DONE) in_cnt <= '0;
    else if (in_hs) in_cnt <= in_cnt + 1'b1;
  end

  // two-stage scale pipeline: rounded product, then shift and saturate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      s2_v <= 1'b0;
      s2_last <= 1'b0;
      s2_data <= '0;
      for (int l = 0; l < LANES; l++) p1[l] <= '0;
    end else begin
      s1_v <= in_hs;
      s1_last <= in_hs && in_cnt == IW'(FRAME_BEATS - 1);
      for (int l = 0; l < LANES; l++)
        p1[l] <= PW'(io.s_axis_tdata[l*PIX_W +: PIX_W]) * PW'(eff_coef) + HALF;
      s2_v <= s1_v;
      s2_last <= s1_last;
      s2_data <= sat;
    end
  end

  // per-lane saturation to full scale
  always_comb begin
    sat = '0;
    for (int l = 0; l < LANES; l++)
      sat[l*PIX_W +: PIX_W] = p1[l][PW-1:FRAC_W] > HW'(SCALE) ? SCALE : p1[l][FRAC_W +: PIX_W];
  end

  // FIFO storage; credit flow control guarantees a free entry on every write
  always_ff @(posedge clk) begin
    if (s2_v) mem[wr] <= {s2_last, s2_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + AW'(s2_v);
      rd <= rd + AW'(out_hs);
      cnt <= cnt + (AW+1)'(s2_v) - (AW+1)'(out_hs);
    end
  end

  assign io.m_axis_tvalid = cnt != '0;
  assign {io.m_axis_tlast, io.m_axis_tdata} = io.m_axis_tvalid ? mem[rd] : '0;
endmodule

// File: tb/tb_norm_stream_scaler.sv
// tb_norm_stream_scaler: randomized self-checking bench for norm_stream_scaler
module tb_norm_stream_scaler;
  logic clk = 0, reset = 1, sel = 0, ap_start = 0, s_tvalid = 0, m_tready = 0;
  logic [7:0] den = 0;
  logic [31:0] s_tdata = 0;
  logic ap_ready, ap_idle, ap_done, s_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  int checks = 0, failures = 0, cyc = 0, last_done = -10;
  int pix [100];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  norm_stream_scaler_if #(.PIX_W(8), .LANES(1)) ifa ();
  norm_stream_scaler_if #(.PIX_W(8), .LANES(4)) ifb ();

  assign ifa.ap_start = !sel && ap_start;
  assign ifa.norm_denominator = den;
  assign ifa.s_axis_tvalid = !sel && s_tvalid;
  assign ifa.s_axis_tdata = s_tdata[7:0];
  assign ifa.m_axis_tready = sel || m_tready;
  assign ifb.ap_start = sel && ap_start;
  assign ifb.norm_denominator = den;
  assign ifb.s_axis_tvalid = sel && s_tvalid;
  assign ifb.s_axis_tdata = s_tdata;
  assign ifb.m_axis_tready = !sel || m_tready;

  always_comb begin
    ap_ready = sel ? ifb.ap_ready : ifa.ap_ready;
    ap_idle = sel ? ifb.ap_idle : ifa.ap_idle;
    ap_done = sel ? ifb.ap_done : ifa.ap_done;
    s_tready = sel ? ifb.s_axis_tready : ifa.s_axis_tready;
    m_tvalid = sel ? ifb.m_axis_tvalid : ifa.m_axis_tvalid;
    m_tlast = sel ? ifb.m_axis_tlast : ifa.m_axis_tlast;
    m_tdata = sel ? ifb.m_axis_tdata : {24'b0, ifa.m_axis_tdata};
  end

  norm_stream_scaler dut_a (.clk(clk), .reset(reset), .io(ifa.slave));
  norm_stream_scaler #(.LANES(4), .FIFO_DEPTH(4)) dut_b (.clk(clk), .reset(reset), .io(ifb.slave));

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int model(input int d, input int p);
    longint c, r;
    if (d == 0) return p;
    c = (longint'(255) << 16) / d;
    r = (p * c + 32768) >> 16;
    return r > 255 ? 255 : int'(r);
  endfunction

  function automatic logic [31:0] in_beat(input int b, input int lanes);
    logic [31:0] v = '0;
    if (b < 100 / lanes)
      for (int l = 0; l < lanes; l++) v[l*8 +: 8] = 8'(pix[b*lanes+l]);
    return v;
  endfunction

  function automatic logic [31:0] exp_beat(input int b, input int d, input int lanes);
    logic [31:0] v = '0;
    for (int l = 0; l < lanes; l++) v[l*8 +: 8] = 8'(model(d, pix[b*lanes+l]));
    return v;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 100; i++)
      pix[i] = mode == 0 ? 64 : mode == 1 ? (i % 3 == 0 ? 200 : i % 3 == 1 ? 0 : 255) :
               mode == 2 ? i : mode == 3 ? 16 : int'($urandom_range(0, 255));
  endtask

  task automatic run_frame(input int d, input int duty, input int vduty, input bit poke,
                           input int abort_at, input bit b2b);
    int lanes = sel ? 4 : 1;
    int beats = 100 / lanes;
    int depth = sel ? 4 : 16;
    int ii = 0, oi = 0, st = 0, first_rdy = -1, first_in = -1, first_out = -1;
    int last_out = -1, done_cyc = -1, late = 0, maxocc = 0, t0 = cyc;
    bit ih, oh, held = 0, poked = 0;
    logic [32:0] hv = '0;
    while (!ap_ready && cyc - t0 < 100) begin @(posedge clk); #1; end
    check("start_ready", ap_ready, 1);
    if (b2b) check("b2b_start", cyc, last_done + 1);
    st = cyc;
    ap_start = 1;
    den = 8'(d);
    s_tvalid = 0;
    m_tready = $urandom_range(0, 99) < duty;
    for (int k = 0; k < 3000 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (first_rdy < 0 && s_tready) first_rdy = cyc;
      if (ii == beats && s_tready) late++;
      if (held) check("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, hv});
      held = m_tvalid && !m_tready;
      hv = {m_tlast, m_tdata};
      ih = s_tvalid && s_tready;
      oh = m_tvalid && m_tready;
      if (ih) begin
        if (first_in < 0) first_in = cyc;
        ii++;
      end
      if (oh) begin
        if (first_out < 0) first_out = cyc;
        check("data", m_tdata, exp_beat(oi, d, lanes));
        check("last", m_tlast, oi == beats - 1);
        oi++;
        last_out = cyc;
      end
      if (ii - oi > maxocc) maxocc = ii - oi;
      if (ap_done) done_cyc = cyc;
      if (abort_at > 0 && oi >= abort_at) begin
        reset = 1;
        #1;
        check("reset_outputs", {ap_ready, ap_idle, ap_done, s_tready, m_tvalid, m_tlast, m_tdata}, 0);
        check("abort_no_done", done_cyc, -1);
        @(posedge clk); #1;
        reset = 0;
        ap_start = 0;
        s_tvalid = 0;
        return;
      end
      if (done_cyc < 0) begin
        @(posedge clk); #1;
        ap_start = 0;
        if (poke && !poked && ii == beats / 2) begin
          ap_start = 1;
          den = ~den;
          poked = 1;
        end
        if (ih || !s_tvalid) begin
          s_tvalid = ii < beats && $urandom_range(0, 99) < vduty;
          s_tdata = in_beat(ii, lanes);
        end
        m_tready = $urandom_range(0, 99) < duty;
      end
    end
    check("beats_out", oi, beats);
    check("beats_in", ii, beats);
    check("done_latency", done_cyc - last_out, 1);
    check("ready_latency", first_rdy - st, d == 0 ? 1 : 25);
    check("tready_after_frame", late, 0);
    check("credit", maxocc <= depth, 1);
    if (duty == 100 && vduty == 100) begin
      check("pipe_latency", first_out - first_in, 3);
      check("throughput", last_out - first_out, beats - 1);
    end
    last_done = done_cyc;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {ap_ready, ap_idle, ap_done, s_tready, m_tvalid, m_tlast, m_tdata}, 0);
    @(posedge clk); #1;
    reset = 0;
    check("ready_before_edge", ap_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", ap_ready, 1);
    check("idle_after_edge", ap_idle, 1);
    fill(0);
    run_frame(128, 100, 100, 0, 0, 0);
    fill(1);
    run_frame(128, 70, 80, 0, 0, 0);
    fill(4);
    pix[0] = 1;
    pix[7] = 1;
    run_frame(3, 60, 70, 0, 0, 0);
    fill(4);
    pix[0] = 100;
    run_frame(255, 80, 90, 0, 0, 0);
    fill(2);
    run_frame(0, 100, 100, 0, 0, 0);
    fill(4);
    run_frame(int'($urandom_range(1, 255)), 50, 60, 1, 0, 0);
    check("idle_after_poke", ap_idle, 1);
    fill(4);
    run_frame(128, 100, 100, 0, 50, 0);
    fill(4);
    run_frame(255, 100, 100, 0, 0, 0);
    fill(3);
    run_frame(64, 100, 100, 0, 0, 0);
    run_frame(32, 100, 100, 0, 0, 1);
    sel = 1;
    for (int r = 0; r < 3; r++) begin
      fill(4);
      run_frame(r == 2 ? 0 : int'($urandom_range(1, 255)), 30, r == 1 ? 50 : 100, 0, 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
